// File: rtl/fifo_lvl.sv
// Synchronous elastic FIFO with occupancy count, threshold flags, show-ahead or registered read,
// and overflow/underflow reporting. Define FIFO_LVL_STICKY_ERR_EN for sticky error flags with clr_err.
module fifo_lvl #(
  parameter int D_WIDTH    = 32,
  parameter int ADDR_W     = 4,
  parameter int AF_LEVEL   = (1 << ADDR_W) - 2,
  parameter int AE_LEVEL   = 1,
  parameter int SHOW_AHEAD = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [D_WIDTH-1:0] d,
`ifdef FIFO_LVL_STICKY_ERR_EN
  input  logic               clr_err,
`endif
  output logic [D_WIDTH-1:0] q,
  output logic               q_valid,
  output logic [ADDR_W:0]    count,
  output logic               empty,
  output logic               full,
  output logic               almost_empty,
  output logic               almost_full,
  output logic               overflow,
  output logic               underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]    wr_ptr;
  logic [ADDR_W:0]    rd_ptr;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr;
  logic               pop_ok;
  logic               push_ok;
  logic               ovf_evt;
  logic               unf_evt;

  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];

  // Flags come only from the pointer registers, so push/pop never reach them combinationally.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_addr == rd_addr) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ovf_evt = push & ~push_ok;
  assign unf_evt = pop & empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is data-only and deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_addr] <= d;
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      assign q       = empty ? '0 : mem[rd_addr];
      assign q_valid = ~empty;
    end else begin : g_registered
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q       <= '0;
          q_valid <= 1'b0;
        end else if (pop_ok) begin
          q       <= mem[rd_addr];
          q_valid <= 1'b1;
        end else begin
          q_valid <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
`ifdef FIFO_LVL_STICKY_ERR_EN
      // A new event in the same cycle as clr_err keeps the flag set.
      overflow  <= ovf_evt | (overflow & ~clr_err);
      underflow <= unf_evt | (underflow & ~clr_err);
`else
      overflow  <= ovf_evt;
      underflow <= unf_evt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_lvl.sv
// Randomized and directed bench for fifo_lvl: a show-ahead and a registered-read instance
// share stimulus and are compared against a queue-based reference model.
module tb_fifo_lvl;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       push  = 1'b0;
  logic       pop   = 1'b0;
  logic [7:0] d     = 8'h00;
`ifdef FIFO_LVL_STICKY_ERR_EN
  logic       clr_err = 1'b0;
`endif

  logic [7:0] q_a, q_b;
  logic       qv_a, qv_b;
  logic [2:0] count_a, count_b;
  logic       empty_a, empty_b, full_a, full_b;
  logic       ae_a, ae_b, af_a, af_b;
  logic       ovf_a, ovf_b, unf_a, unf_b;

  fifo_lvl #(.D_WIDTH(8), .ADDR_W(2), .AF_LEVEL(3), .AE_LEVEL(1), .SHOW_AHEAD(1)) dut_a (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .d(d),
`ifdef FIFO_LVL_STICKY_ERR_EN
    .clr_err(clr_err),
`endif
    .q(q_a), .q_valid(qv_a), .count(count_a), .empty(empty_a), .full(full_a),
    .almost_empty(ae_a), .almost_full(af_a), .overflow(ovf_a), .underflow(unf_a)
  );

  fifo_lvl #(.D_WIDTH(8), .ADDR_W(2), .AF_LEVEL(3), .AE_LEVEL(1), .SHOW_AHEAD(0)) dut_b (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .d(d),
`ifdef FIFO_LVL_STICKY_ERR_EN
    .clr_err(clr_err),
`endif
    .q(q_b), .q_valid(qv_b), .count(count_b), .empty(empty_b), .full(full_b),
    .almost_empty(ae_b), .almost_full(af_b), .overflow(ovf_b), .underflow(unf_b)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, registered-read output and error flags.
  logic [7:0] mq [$];
  logic [7:0] m_qr;
  logic       m_qv;
  logic       m_ovf;
  logic       m_unf;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    logic [7:0] head;
    sz   = mq.size();
    head = (sz > 0) ? mq[0] : 8'h00;
    chk("count_a", 32'(count_a), 32'(sz));
    chk("count_b", 32'(count_b), 32'(sz));
    chk("empty_a", 32'(empty_a), 32'(sz == 0));
    chk("empty_b", 32'(empty_b), 32'(sz == 0));
    chk("full_a",  32'(full_a),  32'(sz == 4));
    chk("full_b",  32'(full_b),  32'(sz == 4));
    chk("ae_a",    32'(ae_a),    32'(sz <= 1));
    chk("ae_b",    32'(ae_b),    32'(sz <= 1));
    chk("af_a",    32'(af_a),    32'(sz >= 3));
    chk("af_b",    32'(af_b),    32'(sz >= 3));
    chk("q_a",     32'(q_a),     32'(head));
    chk("qv_a",    32'(qv_a),    32'(sz > 0));
    chk("q_b",     32'(q_b),     32'(m_qr));
    chk("qv_b",    32'(qv_b),    32'(m_qv));
    chk("ovf_a",   32'(ovf_a),   32'(m_ovf));
    chk("ovf_b",   32'(ovf_b),   32'(m_ovf));
    chk("unf_a",   32'(unf_a),   32'(m_unf));
    chk("unf_b",   32'(unf_b),   32'(m_unf));
  endtask

  // Drive one cycle from the negedge, advance the model, check at the next negedge.
  task automatic cycle(input logic p, input logic r, input logic [7:0] dv);
    int   sz;
    logic pok, wok, evt_o, evt_u;
    push = p;
    pop  = r;
    d    = dv;
    sz    = mq.size();
    pok   = r && (sz > 0);
    wok   = p && ((sz < 4) || pok);
    evt_o = p && !wok;
    evt_u = r && (sz == 0);
    if (pok) begin
      m_qr = mq.pop_front();
      m_qv = 1'b1;
    end else begin
      m_qv = 1'b0;
    end
    if (wok) mq.push_back(dv);
`ifdef FIFO_LVL_STICKY_ERR_EN
    m_ovf = evt_o | (m_ovf & ~clr_err);
    m_unf = evt_u | (m_unf & ~clr_err);
`else
    m_ovf = evt_o;
    m_unf = evt_u;
`endif
    @(posedge clk);
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
`ifdef FIFO_LVL_STICKY_ERR_EN
    clr_err = 1'b0;
`endif
    check_all();
  endtask

  // Asserted away from the clock edge so the outputs must clear asynchronously.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    mq.delete();
    m_qr  = 8'h00;
    m_qv  = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk("rst_count_a", 32'(count_a), 32'd0);
    chk("rst_count_b", 32'(count_b), 32'd0);
    chk("rst_empty_a", 32'(empty_a), 32'd1);
    chk("rst_qv_a",    32'(qv_a),    32'd0);
    chk("rst_qv_b",    32'(qv_b),    32'd0);
    chk("rst_q_b",     32'(q_b),     32'd0);
    chk("rst_ovf_a",   32'(ovf_a),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_all();
  endtask

  logic [7:0] seq1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    @(negedge clk);
    apply_reset();

    // Fill to full, then drain in order.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, seq1[i]);
    chk("t1_full",  32'(full_a),  32'd1);
    chk("t1_count", 32'(count_a), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_head", 32'(q_a), 32'(seq1[i]));
      cycle(1'b0, 1'b1, 8'h00);
      chk("t1_pop_b", 32'(q_b), 32'(seq1[i]));
    end
    chk("t1_empty", 32'(empty_a), 32'd1);
    chk("t1_q0",    32'(q_a),     32'd0);

    // Simultaneous push/pop while full, then a rejected push.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, seq1[i]);
    cycle(1'b1, 1'b1, 8'h55);
    chk("t2_popped", 32'(q_b),     32'h11);
    chk("t2_count",  32'(count_a), 32'd4);
    chk("t2_noovf",  32'(ovf_a),   32'd0);
    cycle(1'b1, 1'b0, 8'h66);
    chk("t2_ovf",    32'(ovf_a),   32'd1);
    cycle(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);
    chk("t2_last",   32'(q_b),     32'h55);

    // Push plus pop into an empty FIFO.
    cycle(1'b1, 1'b1, 8'hA5);
    chk("t3_unf",   32'(unf_a),   32'd1);
    chk("t3_count", 32'(count_a), 32'd1);
    chk("t3_q",     32'(q_a),     32'hA5);
    cycle(1'b0, 1'b1, 8'h00);
    chk("t4_qb",  32'(q_b),  32'hA5);
    chk("t4_qvb", 32'(qv_b), 32'd1);
    cycle(1'b0, 1'b0, 8'h00);
    chk("t4_qvb_idle", 32'(qv_b), 32'd0);

    // Streaming across pointer wrap.
    cycle(1'b1, 1'b0, 8'd0);
    for (int i = 1; i < 20; i++) begin
      cycle(1'b1, 1'b1, 8'(i));
      chk("t5_wrap", 32'(q_b), 32'(i - 1));
    end
    cycle(1'b0, 1'b1, 8'h00);
    chk("t5_wrap_end", 32'(q_b), 32'd19);

    // Random traffic with alternating fill and drain bias.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = ((i / 40) % 2 == 0) ? 75 : 25;
`ifdef FIFO_LVL_STICKY_ERR_EN
      clr_err = ($urandom_range(0, 9) == 0);
`endif
      cycle($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
            8'($urandom));
    end

`ifdef FIFO_LVL_STICKY_ERR_EN
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    chk("t6_sticky", 32'(ovf_a), 32'd1);
    clr_err = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);
    chk("t6_clr", 32'(ovf_a), 32'd0);
`endif

    // Reset mid-stream with three entries held.
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i));
    cycle(1'b1, 1'b1, 8'hC3);
    chk("t6_count3", 32'(count_a), 32'd3);
    apply_reset();
    cycle(1'b1, 1'b0, 8'h7E);
    chk("t6_after", 32'(q_a), 32'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
